// File: rtl/sum_uart_tx.sv
// rtl/sum_uart_tx.sv - byte FIFO feeding an 8N1 LSB-first UART transmitter
module sum_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_next;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [7:0]    shift, shift_next;
    logic [BW-1:0] baud, baud_next;
    logic [2:0]    bit_idx, bit_next;
    logic          full, push, pop, tx_next, baud_wrap, have_data;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level     = wr_ptr - rd_ptr;
    assign have_data = (level != '0);
    assign in_ready  = !full && !rst;
    assign push      = in_valid && in_ready;
    assign busy      = (state != IDLE) || have_data;
    assign baud_wrap = (baud == BAUD_LAST);

    always_comb begin
        state_next = state;
        shift_next = shift;
        baud_next  = baud;
        bit_next   = bit_idx;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (have_data) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr[AW-1:0]];
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                if (baud_wrap) begin
                    baud_next  = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud + BW'(1);
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end else begin
                    baud_next = baud + BW'(1);
                end
            end
            STOP: begin
                if (baud_wrap) begin
                    baud_next = '0;
                    // Chain straight into the next start bit so queued frames are contiguous.
                    if (have_data) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr[AW-1:0]];
                        bit_next   = '0;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud + BW'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            shift   <= '0;
            baud    <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_next;
            shift   <= shift_next;
            baud    <= baud_next;
            bit_idx <= bit_next;
            tx      <= tx_next;
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

endmodule
